// File: rtl/sump_cmd_pkg.sv
// Shared types and SUMP opcode constants for the command assembler.
package sump_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARG  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0] OP_RESET      = 8'h00;
    localparam logic [7:0] OP_RUN        = 8'h01;
    localparam logic [7:0] OP_ID         = 8'h02;
    localparam logic [7:0] OP_META       = 8'h04;
    localparam logic [7:0] OP_RLE_FINISH = 8'h05;
    localparam logic [7:0] OP_DIV        = 8'h80;
    localparam logic [7:0] OP_CNT        = 8'h81;
    localparam logic [7:0] OP_FLAGS      = 8'h82;
    localparam logic [7:0] OP_TRIG_MASK0 = 8'hC0;
    localparam logic [7:0] OP_TRIG_VAL0  = 8'hC1;
    localparam logic [7:0] OP_TRIG_CFG0  = 8'hC2;

    localparam int LONG_BIT = 7;

    // Long commands carry four argument bytes after the opcode.
    function automatic logic is_long(input logic [7:0] opcode);
        return opcode[LONG_BIT];
    endfunction

endpackage

// File: rtl/sump_cmd_assembler_if.sv
// Byte-in / command-out bundle between the SPI byte receiver, the assembler and the register file.
interface sump_cmd_assembler_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        exec_valid;
    logic        exec_ready;
    logic [7:0]  exec_opcode;
    logic [31:0] exec_data;
    logic        exec_long;
    logic        soft_reset;
    logic        timeout_err;
    logic        overrun;
    logic        overrun_clr;
    logic        busy;

    modport slave (
        input  rx_valid, rx_data, exec_ready, overrun_clr,
        output exec_valid, exec_opcode, exec_data, exec_long,
               soft_reset, timeout_err, overrun, busy
    );

    modport master (
        output rx_valid, rx_data, exec_ready, overrun_clr,
        input  exec_valid, exec_opcode, exec_data, exec_long,
               soft_reset, timeout_err, overrun, busy
    );
endinterface

// File: rtl/sump_cmd_timer.sv
// Inter-byte timeout counter: counts enabled cycles and flags when the limit is reached.
module sump_cmd_timer #(
    parameter int LIMIT = 65536,
    parameter int CNT_W = 17
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count_reg;

    assign expire = (count_reg == CNT_W'(LIMIT - 1));

    // Saturate at the limit; the owner drops out of the counting state on expire.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expire) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sump_cmd_assembler.sv
// Collects SUMP command bytes into complete short/long commands and holds each one
// until the command engine accepts it.
module sump_cmd_assembler
    import sump_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int CNT_W          = 17
) (
    input  logic                 clock,
    input  logic                 reset,
    sump_cmd_assembler_if.slave  bus
);

    state_t      state_reg, state_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic [7:0]  opcode_reg, opcode_next;
    logic [31:0] data_reg, data_next;
    logic        long_reg, long_next;
    logic        soft_reset_reg, soft_reset_next;
    logic        timeout_reg, timeout_next;
    logic        overrun_reg, overrun_next;
    logic        overrun_set;
    logic        take_opcode;
    logic        timer_clear, timer_enable, timer_expire;
    logic [3:0]  lane_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_sel[gi] = (cnt_reg == 2'(gi));
    end

    // The timer only runs while waiting for argument bytes; every byte restarts it.
    assign timer_enable = (state_reg == ARG);
    assign timer_clear  = (state_reg != ARG) || bus.rx_valid;

    sump_cmd_timer #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expire (timer_expire)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            opcode_reg     <= '0;
            data_reg       <= '0;
            long_reg       <= 1'b0;
            soft_reset_reg <= 1'b0;
            timeout_reg    <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            opcode_reg     <= opcode_next;
            data_reg       <= data_next;
            long_reg       <= long_next;
            soft_reset_reg <= soft_reset_next;
            timeout_reg    <= timeout_next;
            overrun_reg    <= overrun_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        opcode_next     = opcode_reg;
        data_next       = data_reg;
        long_next       = long_reg;
        soft_reset_next = 1'b0;
        timeout_next    = 1'b0;
        overrun_set     = 1'b0;
        take_opcode     = 1'b0;

        unique case (state_reg)
            IDLE: begin
                take_opcode = bus.rx_valid;
            end
            ARG: begin
                if (bus.rx_valid) begin
                    for (int i = 0; i < 4; i++) begin
                        if (lane_sel[i]) begin
                            data_next[8*i +: 8] = bus.rx_data;
                        end
                    end
                    cnt_next = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        state_next = HOLD;
                        long_next  = 1'b1;
                    end
                end else if (timer_expire) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                    data_next    = '0;
                    cnt_next     = '0;
                end
            end
            HOLD: begin
                if (bus.exec_ready) begin
                    // Handshake done; a byte in the same cycle starts the next command.
                    state_next  = IDLE;
                    take_opcode = bus.rx_valid;
                end else if (bus.rx_valid) begin
                    overrun_set = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (take_opcode) begin
            if (bus.rx_data == OP_RESET) begin
                soft_reset_next = 1'b1;
                state_next      = IDLE;
            end else begin
                opcode_next = bus.rx_data;
                data_next   = '0;
                long_next   = 1'b0;
                cnt_next    = '0;
                state_next  = is_long(bus.rx_data) ? ARG : HOLD;
            end
        end

        overrun_next = overrun_set || (overrun_reg && !bus.overrun_clr);
    end

    assign bus.exec_valid  = (state_reg == HOLD);
    assign bus.exec_opcode = opcode_reg;
    assign bus.exec_data   = data_reg;
    assign bus.exec_long   = long_reg;
    assign bus.soft_reset  = soft_reset_reg;
    assign bus.timeout_err = timeout_reg;
    assign bus.overrun     = overrun_reg;
    assign bus.busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_sump_cmd_assembler.sv
// Directed plus randomized check of the SUMP command assembler against a byte-queue reference model.
module tb_sump_cmd_assembler;

    localparam int TO = 16;

    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    sump_cmd_assembler_if bus();

    sump_cmd_assembler #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: a pending command, the bytes of a partial long command, and a silence count.
    bit          m_pend;
    logic [7:0]  m_op;
    logic [31:0] m_data;
    bit          m_long;
    logic [7:0]  m_part[$];
    int          m_silent;
    bit          m_ovr;
    bit          e_soft;
    bit          e_to;

    task automatic model_reset();
        m_pend = 0; m_op = '0; m_data = '0; m_long = 0;
        m_part.delete(); m_silent = 0; m_ovr = 0; e_soft = 0; e_to = 0;
    endtask

    task automatic model_step(input bit rv, input logic [7:0] rd, input bit rdy, input bit clr);
        bit take;
        bit ovr_set;
        take = 0; ovr_set = 0; e_soft = 0; e_to = 0;
        if (m_pend) begin
            if (rdy) begin
                m_pend = 0;
                take = rv;
            end else if (rv) begin
                ovr_set = 1;
            end
        end else if (m_part.size() > 0) begin
            if (rv) begin
                m_part.push_back(rd);
                m_silent = 0;
                if (m_part.size() == 5) begin
                    m_pend = 1; m_long = 1; m_op = m_part[0];
                    m_data = {m_part[4], m_part[3], m_part[2], m_part[1]};
                    m_part.delete();
                end
            end else begin
                m_silent++;
                if (m_silent == TO) begin
                    m_part.delete();
                    e_to = 1;
                end
            end
        end else begin
            take = rv;
        end
        if (take) begin
            if (rd == 8'h00) begin
                e_soft = 1;
            end else if (rd < 8'h80) begin
                m_pend = 1; m_op = rd; m_data = '0; m_long = 0;
            end else begin
                m_part.delete();
                m_part.push_back(rd);
                m_silent = 0;
            end
        end
        m_ovr = ovr_set || (m_ovr && !clr);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("exec_valid", 32'(bus.exec_valid), 32'(m_pend));
        chk("soft_reset", 32'(bus.soft_reset), 32'(e_soft));
        chk("timeout_err", 32'(bus.timeout_err), 32'(e_to));
        chk("overrun", 32'(bus.overrun), 32'(m_ovr));
        chk("busy", 32'(bus.busy), 32'(m_pend || (m_part.size() > 0)));
        if (m_pend) begin
            chk("exec_opcode", 32'(bus.exec_opcode), 32'(m_op));
            chk("exec_data", bus.exec_data, m_data);
            chk("exec_long", 32'(bus.exec_long), 32'(m_long));
        end
    endtask

    task automatic check_all_zero(input string phase);
        chk({phase, "_valid"}, 32'(bus.exec_valid), 32'd0);
        chk({phase, "_opcode"}, 32'(bus.exec_opcode), 32'd0);
        chk({phase, "_data"}, bus.exec_data, 32'd0);
        chk({phase, "_long"}, 32'(bus.exec_long), 32'd0);
        chk({phase, "_soft"}, 32'(bus.soft_reset), 32'd0);
        chk({phase, "_timeout"}, 32'(bus.timeout_err), 32'd0);
        chk({phase, "_overrun"}, 32'(bus.overrun), 32'd0);
        chk({phase, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic cycle(input bit rv, input logic [7:0] rd, input bit rdy, input bit clr);
        bus.rx_valid    = rv;
        bus.rx_data     = rd;
        bus.exec_ready  = rdy;
        bus.overrun_clr = clr;
        @(posedge clock);
        model_step(rv, rd, rdy, clr);
        #1;
        compare_all();
        $display("cyc rv=%0d rd=%h rdy=%0d clr=%0d -> valid=%0d op=%h data=%h long=%0d soft=%0d to=%0d ovr=%0d",
                 rv, rd, rdy, clr, bus.exec_valid, bus.exec_opcode, bus.exec_data,
                 bus.exec_long, bus.soft_reset, bus.timeout_err, bus.overrun);
    endtask

    initial begin
        logic [7:0] ops [10];
        logic [7:0] rd;
        bit         rv;
        ops = '{8'h01, 8'h02, 8'h04, 8'h05, 8'h80, 8'h81, 8'h82, 8'hC0, 8'hC1, 8'hC2};

        reset = 1'b1;
        bus.rx_valid = 0; bus.rx_data = '0; bus.exec_ready = 0; bus.overrun_clr = 0;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_all_zero("por");

        // Reset in the middle of a long command.
        cycle(1, 8'hC0, 0, 0);
        cycle(1, 8'h11, 0, 0);
        cycle(1, 8'h22, 0, 0);
        reset = 1'b1;
        #1;
        check_all_zero("mid_arg_reset");
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        cycle(1, 8'h01, 0, 0);
        cycle(0, 8'h00, 1, 0);

        // Long command containing zero argument bytes.
        cycle(1, 8'hC0, 1, 0);
        cycle(1, 8'hFF, 1, 0);
        cycle(1, 8'h00, 1, 0);
        cycle(1, 8'h00, 1, 0);
        cycle(1, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);

        // Back-to-back soft resets.
        for (int i = 0; i < 5; i++) cycle(1, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);

        // Partial long command times out, then a short command goes through.
        cycle(1, 8'h81, 0, 0);
        cycle(1, 8'h0F, 0, 0);
        cycle(1, 8'h00, 0, 0);
        for (int i = 0; i < TO + 2; i++) cycle(0, 8'h00, 0, 0);
        cycle(1, 8'h02, 0, 0);
        cycle(0, 8'h00, 1, 0);

        // Byte arriving on the timeout limit cycle wins.
        cycle(1, 8'h82, 0, 0);
        for (int i = 0; i < TO - 1; i++) cycle(0, 8'h00, 0, 0);
        cycle(1, 8'hAB, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'h10 + i), 0, 0);
        cycle(0, 8'h00, 1, 0);

        // Overrun and its clear.
        cycle(1, 8'h01, 0, 0);
        cycle(1, 8'h02, 0, 0);
        cycle(0, 8'h00, 0, 0);
        cycle(0, 8'h00, 1, 1);

        // Zero-bubble handoff.
        cycle(1, 8'h01, 0, 0);
        cycle(1, 8'h02, 1, 0);
        cycle(0, 8'h00, 1, 0);

        // Randomized traffic with periodic quiet stretches long enough to time out.
        for (int i = 0; i < 3000; i++) begin
            int sel;
            rv = ((i % 200) < 170) ? ($urandom_range(0, 2) == 0) : 1'b0;
            sel = $urandom_range(0, 9);
            if (sel == 0)      rd = 8'h00;
            else if (sel < 6)  rd = ops[$urandom_range(0, 9)];
            else               rd = 8'($urandom);
            cycle(rv, rd, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sump_cmd_assembler.md
Name: sump_cmd_assembler

Overview:
Sequences the SUMP command byte stream from the SPI slave into complete commands for the core's command engine. Short commands are 1 byte (opcode bit7=0). Long commands are 5 bytes (opcode bit7=1, then 4 argument bytes, LSB first). The block sits between the SPI slave byte receiver and the trigger/flags/divider/count register file. It provides an inter-byte timeout, holds each command until the consumer accepts it, and flags overruns.

Parameters:
TIMEOUT_CYCLES, 65536, clock cycles allowed between argument bytes before a partial long command is discarded (min 2)
CNT_W, 17, width of timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clock  in  1  core clock
reset  in  1  asynchronous, active-high reset
rx_valid  in  1  one-cycle strobe: rx_data holds a received SPI byte
rx_data  in  8  received byte
exec_valid  out  1  complete command pending
exec_ready  in  1  consumer accepts command this cycle when exec_valid=1
exec_opcode  out  8  command opcode
exec_data  out  32  argument, {b4,b3,b2,b1}; 0 for short commands
exec_long  out  1  1 = long command
soft_reset  out  1  one-cycle pulse on opcode 0x00
timeout_err  out  1  one-cycle pulse when a partial long command is dropped
overrun  out  1  sticky: byte arrived while a command was pending
overrun_clr  in  1  clears overrun (reset also clears it)
busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, arg count=0, timer=0. All outputs=0; exec_opcode/exec_data=0.
- States: IDLE, ARG, HOLD.
- IDLE, rx_valid=1:
  - rx_data=0x00 -> soft_reset=1 next cycle; stay IDLE; no exec.
  - Other bit7=0 opcode -> latch opcode, exec_long=0, exec_data=0 -> HOLD; exec_valid=1 next cycle.
  - bit7=1 -> latch opcode, exec_data=0, cnt=0, timer=0 -> ARG.
- ARG, rx_valid=1: write byte into exec_data[8*cnt+:8]; cnt++; timer=0. The 4th byte -> HOLD, exec_long=1. Bytes of value 0x00 are data here and never soft_reset.
- ARG, no byte: timer++. When timer reaches TIMEOUT_CYCLES-1 -> IDLE, timeout_err pulse, partial data discarded (exec_data cleared).
- ARG, rx_valid in the same cycle timer hits its limit: the byte wins, and the timer is cleared.
- HOLD: exec_valid=1, outputs stable until exec_ready=1. On exec_ready the transfer completes and exec_valid falls next cycle unless re-asserted.
- HOLD, rx_valid=1 with exec_ready=1 in the same cycle: handshake completes and the byte is processed as in IDLE (zero-bubble). A back-to-back short opcode keeps exec_valid high with the new opcode.
- HOLD, rx_valid=1 with exec_ready=0: byte dropped; overrun=1.
- overrun: set has priority over overrun_clr in the same cycle.
- Latency: exec_valid rises 1 cycle after the final byte's rx_valid.
- No timeout in HOLD or IDLE.

Decomposition:
- Package sump_cmd_pkg:
  - state enum {IDLE, ARG, HOLD}
  - opcode constants: OP_RESET=0x00, OP_RUN=0x01, OP_ID=0x02, OP_META=0x04, OP_RLE_FINISH=0x05, OP_DIV=0x80, OP_CNT=0x81, OP_FLAGS=0x82, OP_TRIG_MASK0=0xC0, OP_TRIG_VAL0=0xC1, OP_TRIG_CFG0=0xC2
  - LONG_BIT=7
- One sub-module: sump_cmd_timer (clear/enable/expire, width CNT_W) for the inter-byte timeout.

Test Plan:
- Reset mid-ARG after 2 argument bytes -> all outputs 0, state IDLE; next byte 0x01 gives exec_opcode=0x01, exec_long=0.
- Bytes 0xC0,0xFF,0x00,0x00,0x00, exec_ready=1 -> exec_valid one cycle after last byte; exec_opcode=0xC0, exec_data=0x000000FF, exec_long=1; no soft_reset despite the 0x00 bytes.
- Five 0x00 bytes in IDLE -> five soft_reset pulses, exec_valid never asserted.
- 0x81,0x0F,0x00 then silence TIMEOUT_CYCLES (TIMEOUT_CYCLES=16 build) -> timeout_err pulse, IDLE. Then 0x02 -> exec_opcode=0x02.
- 0x01 with exec_ready=0, then 0x02 -> overrun=1, exec_opcode stays 0x01. Raise exec_ready and overrun_clr -> exec_valid=0, overrun=0.
- 0x01 pending; 0x02 arrives in the same cycle as exec_ready=1 -> exec_valid stays high, exec_opcode=0x02, overrun=0.
